jk_counter_bank: RTL and testbench

//  WIDTH-bit register built from JK cells. Mode-selectable: per-bit JK control,

---
 rtl/jk_counter_bank_pkg.sv | 33 +++
 rtl/jk_counter_bank_if.sv | 25 ++
 rtl/jk_counter_bank_cell.sv | 32 +++
 rtl/jk_counter_bank.sv | 97 +++++++++
 tb/tb_jk_counter_bank.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/jk_counter_bank_pkg.sv
// Shared definitions for the JK counter bank: operating modes, JK cell actions
// and the single-cell next-state function.
package jk_counter_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Encoded as {j, k}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_action_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        nxt = q;
        case (jk_action_e'({j, k}))
            JK_HOLD:   nxt = q;
            JK_CLEAR:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_counter_bank_if.sv
// Control/data bundle of the JK counter bank; the controller drives the
// operation, the bank returns its state and terminal-count pulse.
interface jk_counter_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;

    modport master (
        output en, mode, j, k, d,
        input  q, qn, tc
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qn, tc
    );

endinterface

// File: rtl/jk_counter_bank_cell.sv
// Single JK flip-flop with synchronous reset value and a load path that
// overrides the J/K inputs.
module jk_cell
    import jk_counter_bank_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    input  logic i_load,
    input  logic i_d,
    output logic o_q,
    output logic o_qn
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= RESET_BIT;
        else if (i_load)
            r_q <= i_d;
        else
            r_q <= jk_next(r_q, i_j, i_k);
    end

    assign o_q  = r_q;
    assign o_qn = ~r_q;

endmodule

// File: rtl/jk_counter_bank.sv
// Vector of JK cells that acts as a per-bit JK register, up/down counter or
// parallel-load register, with a registered wrap pulse.
module jk_counter_bank
    import jk_counter_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    jk_counter_bank_if.slave  bus
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_borrow;
    logic             w_tcNext;
    logic             r_tc;
    mode_e            w_mode;

    assign w_mode = mode_e'(bus.mode);

    // A cell toggles when every lower bit is 1 (counting up) or 0 (counting down)
    always_comb begin
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_carry[i]  = w_carry[i-1] & w_q[i-1];
            w_borrow[i] = w_borrow[i-1] & w_qn[i-1];
        end
    end

    always_comb begin
        w_j      = '0;
        w_k      = '0;
        w_load   = '0;
        w_d      = '0;
        w_tcNext = 1'b0;
        if (bus.en) begin
            case (w_mode)
                MODE_JK: begin
                    w_j = bus.j;
                    w_k = bus.k;
                end
                MODE_UP: begin
                    w_j      = w_carry;
                    w_k      = w_carry;
                    w_tcNext = &w_q;
                end
                MODE_DOWN: begin
                    w_j      = w_borrow;
                    w_k      = w_borrow;
                    w_tcNext = &w_qn;
                end
                MODE_LOAD: begin
                    w_load = '1;
                    w_d    = bus.d;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RESET_BIT (RESET_VAL[gi])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_j    (w_j[gi]),
            .i_k    (w_k[gi]),
            .i_load (w_load[gi]),
            .i_d    (w_d[gi]),
            .o_q    (w_q[gi]),
            .o_qn   (w_qn[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_tc <= 1'b0;
        else
            r_tc <= w_tcNext;
    end

    assign bus.q  = w_q;
    assign bus.qn = w_qn;
    assign bus.tc = r_tc;

endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed bench for jk_counter_bank at WIDTH=4, with a second instance using
// RESET_VAL=4'hE that shares the same stimulus.
module tb_jk_counter_bank;
    import jk_counter_bank_pkg::*;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    jk_counter_bank_if #(.WIDTH(WIDTH)) busA ();
    jk_counter_bank_if #(.WIDTH(WIDTH)) busB ();

    jk_counter_bank #(.WIDTH(WIDTH), .RESET_VAL(4'h0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    jk_counter_bank #(.WIDTH(WIDTH), .RESET_VAL(4'hE)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both instances always see identical controls
    task automatic drive(input logic en, input logic [1:0] mode,
                         input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
        busA.en = en; busA.mode = mode; busA.j = j; busA.k = k; busA.d = d;
        busB.en = en; busB.mode = mode; busB.j = j; busB.k = k; busB.d = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, MODE_UP, 4'hF, 4'hF, 4'hF);
        for (int n = 0; n < 2; n++) begin
            step();
            vecCount++;
            if (busA.q !== 4'h0 || busA.qn !== 4'hF || busA.tc !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL reset_a edge %0d: q=%b qn=%b tc=%b, want q=0000 qn=1111 tc=0", n, busA.q, busA.qn, busA.tc);
            end
            vecCount++;
            if (busB.q !== 4'hE || busB.qn !== 4'h1 || busB.tc !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL reset_b edge %0d: q=%b qn=%b tc=%b, want q=1110 qn=0001 tc=0", n, busB.q, busB.qn, busB.tc);
            end
        end
        rst = 1'b0;
        drive(1'b0, MODE_UP, 4'hF, 4'hF, 4'hF);
        for (int n = 0; n < 3; n++) begin
            step();
            vecCount++;
            if (busA.q !== 4'h0 || busA.qn !== 4'hF || busA.tc !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL hold_en0 edge %0d: q=%b qn=%b tc=%b, want q=0000 qn=1111 tc=0", n, busA.q, busA.qn, busA.tc);
            end
        end
    endtask

    task automatic test_jk();
        logic [3:0] jv [3];
        logic [3:0] kv [3];
        logic [3:0] qv [3];
        jv = '{4'b1010, 4'b0000, 4'b1111};
        kv = '{4'b0000, 4'b0010, 4'b1111};
        qv = '{4'b1010, 4'b1000, 4'b0111};
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, MODE_JK, jv[n], kv[n], 4'hF);
            step();
            vecCount++;
            if (busA.q !== qv[n] || busA.qn !== ~qv[n] || busA.tc !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL jk step %0d: q=%b qn=%b tc=%b, want q=%b tc=0", n, busA.q, busA.qn, busA.tc, qv[n]);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] expQ;
        rst = 1'b1;
        drive(1'b0, MODE_JK, 4'h0, 4'h0, 4'h0);
        step();
        rst = 1'b0;
        // j/k/d carry junk to show they are ignored while counting
        drive(1'b1, MODE_UP, 4'b0101, 4'b1100, 4'b1001);
        for (int n = 1; n <= 17; n++) begin
            step();
            expQ = 4'(n % 16);
            vecCount++;
            if (busA.q !== expQ || busA.tc !== (n == 16)) begin
                missCount++;
                $display("[TB] FAIL up_count edge %0d: q=%b tc=%b, want q=%b tc=%b", n, busA.q, busA.tc, expQ, (n == 16));
            end
        end
    endtask

    task automatic test_load_down();
        logic [3:0] qv [4];
        logic       tv [4];
        qv = '{4'b0010, 4'b0001, 4'b0000, 4'b1111};
        tv = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b1, MODE_LOAD, 4'hF, 4'hF, 4'b0011);
        step();
        vecCount++;
        if (busA.q !== 4'b0011 || busA.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL load_0011: q=%b tc=%b, want q=0011 tc=0", busA.q, busA.tc);
        end
        drive(1'b1, MODE_DOWN, 4'hA, 4'h5, 4'h0);
        for (int n = 0; n < 4; n++) begin
            step();
            vecCount++;
            if (busA.q !== qv[n] || busA.tc !== tv[n]) begin
                missCount++;
                $display("[TB] FAIL down edge %0d: q=%b tc=%b, want q=%b tc=%b", n, busA.q, busA.tc, qv[n], tv[n]);
            end
        end
        drive(1'b1, MODE_LOAD, 4'h0, 4'h0, 4'b1111);
        step();
        vecCount++;
        if (busA.q !== 4'b1111 || busA.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL load_ones: q=%b tc=%b, want q=1111 tc=0", busA.q, busA.tc);
        end
        // At all-ones but disabled: no wrap, so tc stays low
        drive(1'b0, MODE_UP, 4'h0, 4'h0, 4'h0);
        step();
        vecCount++;
        if (busA.q !== 4'b1111 || busA.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL en0_at_ones: q=%b tc=%b, want q=1111 tc=0", busA.q, busA.tc);
        end
    endtask

    task automatic test_hold_reverse();
        logic [3:0] qv [4];
        drive(1'b1, MODE_LOAD, 4'h0, 4'h0, 4'b0110);
        step();
        qv = '{4'b0111, 4'b0111, 4'b0111, 4'b0110};
        for (int n = 0; n < 4; n++) begin
            case (n)
                0:       drive(1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
                1, 2:    drive(1'b0, MODE_DOWN, 4'hF, 4'hF, 4'hF);
                default: drive(1'b1, MODE_DOWN, 4'h0, 4'h0, 4'h0);
            endcase
            step();
            vecCount++;
            if (busA.q !== qv[n] || busA.tc !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL hold_reverse step %0d: q=%b tc=%b, want q=%b tc=0", n, busA.q, busA.tc, qv[n]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        drive(1'b1, MODE_LOAD, 4'h0, 4'h0, 4'b1000);
        step();
        drive(1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
        step();
        vecCount++;
        if (busA.q !== 4'b1001) begin
            missCount++;
            $display("[TB] FAIL pre_reset: q=%b, want q=1001", busA.q);
        end
        rst = 1'b1;
        step();
        vecCount++;
        if (busA.q !== 4'b0000 || busA.qn !== 4'b1111 || busA.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL mid_reset_a: q=%b qn=%b tc=%b, want q=0000 qn=1111 tc=0", busA.q, busA.qn, busA.tc);
        end
        vecCount++;
        if (busB.q !== 4'b1110 || busB.qn !== 4'b0001 || busB.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL mid_reset_b: q=%b qn=%b tc=%b, want q=1110 qn=0001 tc=0", busB.q, busB.qn, busB.tc);
        end
        rst = 1'b0;
        step();
        vecCount++;
        if (busA.q !== 4'b0001 || busA.tc !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL resume_a: q=%b tc=%b, want q=0001 tc=0", busA.q, busA.tc);
        end
        vecCount++;
        if (busB.q !== 4'b1111 || busB.qn !== 4'b0000) begin
            missCount++;
            $display("[TB] FAIL resume_b: q=%b qn=%b, want q=1111 qn=0000", busB.q, busB.qn);
        end
        step();
        vecCount++;
        if (busB.q !== 4'b0000 || busB.tc !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL wrap_b: q=%b tc=%b, want q=0000 tc=1", busB.q, busB.tc);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        rst       = 1'b1;
        drive(1'b0, MODE_JK, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_jk();
        test_up_wrap();
        test_load_down();
        test_hold_reverse();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
